// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder:
//   - responder FSM state encoding
//   - default data width, byte-address width and storage depth
//   - addr_err(): classifies a byte address as misaligned or out of range
// ----------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int unsigned DEF_DATA_W = 16;
   localparam int unsigned DEF_ADDR_W = 16;
   localparam int unsigned DEF_DEPTH  = 256;

   // Byte address is legal only when half-word aligned and its word index
   // lies inside the array. All upper bits take part in the compare, so an
   // address beyond the array never wraps onto a real word.
   function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
      logic [31:0] word_idx;
      word_idx = addr >> 1;
      return addr[0] | (word_idx >= depth);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// ----------------------------------------------------------------------------
// dmem_array
// Synchronous single-port RAM, DEPTH x DATA_W, with a registered read port.
// The read register doubles as the responder's response-data register, so it
// has an asynchronous reset and a synchronous clear; the storage itself is
// never reset.
//
// Ports:
//   clk    in   clock
//   rst    in   asynchronous active-high reset (read register only)
//   we     in   write enable: mem[idx] <= wdata
//   re     in   read enable:  rdata <= mem[idx]
//   clr    in   synchronous clear of rdata (wins over re)
//   idx    in   word index
//   wdata  in   write data
//   rdata  out  registered read data
// ----------------------------------------------------------------------------
module dmem_array #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned DEPTH  = 256,
   parameter int unsigned IDX_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic              re,
   input  logic              clr,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (clr) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Responder end of the datapath's data-memory port. Accepts one load/store
// at a time over req_valid/req_ready, waits LATENCY cycles, performs the
// access on 16-bit word storage in a single ACCESS cycle, then presents the
// response over resp_valid/resp_ready.
//
// Ports:
//   clk         in   clock
//   rst         in   asynchronous active-high reset
//   req_valid   in   request present
//   req_ready   out  responder can accept a request (IDLE only)
//   req_write   in   1 = store, 0 = load
//   req_addr    in   byte address
//   req_wdata   in   store data
//   resp_valid  out  response present
//   resp_ready  in   initiator accepts the response
//   resp_rdata  out  load data; 0 for stores and errors
//   resp_write  out  echo of the request's write bit
//   resp_err    out  misaligned or out-of-range access
//   busy        out  high in any state other than IDLE
// ----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter int unsigned DEPTH   = DEF_DEPTH,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_write,
   output logic              resp_err,
   output logic              busy
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   // Counter start value; unused when LATENCY = 0 (WAIT is skipped).
   localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              accept;
   logic              acc_err;
   logic              mem_we;
   logic              mem_re;
   logic [IDX_W-1:0]  mem_idx;

   assign accept  = (state == IDLE) && req_valid && req_ready;
   assign acc_err = addr_err(32'(addr_q), DEPTH);
   assign mem_idx = addr_q[IDX_W:1];

   // The array only moves in ACCESS, and only for a legal address.
   assign mem_we = (state == ACCESS) && write_q && !acc_err;
   assign mem_re = (state == ACCESS) && !write_q && !acc_err;

   // write_q is only reloaded on accept, so it is stable throughout RESP.
   assign resp_write = write_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  write_q   <= req_write;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  resp_err  <= 1'b0;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
                  cnt       <= CNT_INIT;
                  state     <= (LATENCY == 0) ? ACCESS : WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  state <= ACCESS;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ACCESS: begin
               resp_err   <= acc_err;
               resp_valid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  busy       <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // The array's read register is the response-data register: cleared on
   // accept so stores and errors return 0, loaded in ACCESS for legal loads.
   dmem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .re    (mem_re),
      .clr   (accept),
      .idx   (mem_idx),
      .wdata (wdata_q),
      .rdata (resp_rdata)
   );

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int unsigned LAT   = 2;
   localparam int unsigned DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = '0;
   logic [15:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [15:0] resp_rdata;
   logic        resp_write;
   logic        resp_err;
   logic        busy;

   logic        z_req_valid = 1'b0;
   logic        z_req_ready;
   logic        z_req_write = 1'b0;
   logic [15:0] z_req_addr = '0;
   logic [15:0] z_req_wdata = '0;
   logic        z_resp_valid;
   logic        z_resp_ready = 1'b0;
   logic [15:0] z_resp_rdata;
   logic        z_resp_write;
   logic        z_resp_err;
   logic        z_busy;

   int total = 0;
   int passed = 0;

   logic [15:0] model_mem [DEPTH];

   always #5 clk = ~clk;

   dmem_responder #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .DEPTH   (DEPTH),
      .LATENCY (LAT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_write (resp_write),
      .resp_err   (resp_err),
      .busy       (busy)
   );

   dmem_responder #(
      .DATA_W  (16),
      .ADDR_W  (16),
      .DEPTH   (DEPTH),
      .LATENCY (0)
   ) dut0 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (z_req_valid),
      .req_ready  (z_req_ready),
      .req_write  (z_req_write),
      .req_addr   (z_req_addr),
      .req_wdata  (z_req_wdata),
      .resp_valid (z_resp_valid),
      .resp_ready (z_resp_ready),
      .resp_rdata (z_resp_rdata),
      .resp_write (z_resp_write),
      .resp_err   (z_resp_err),
      .busy       (z_busy)
   );

   // Reference: a byte address is bad if odd or if its word lies past the array.
   function automatic bit model_err(input logic [15:0] a);
      return ((int'(a) % 2) != 0) || ((int'(a) / 2) >= int'(DEPTH));
   endfunction

   task automatic model_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                            output logic [15:0] exp_rd, output logic exp_e);
      exp_e  = model_err(a);
      exp_rd = '0;
      if (!exp_e) begin
         if (w) model_mem[a / 2] = d;
         else   exp_rd = model_mem[a / 2];
      end
   endtask

   // Drives one request on the LATENCY=2 instance from a negedge, returns the
   // response fields and the cycle count from accept to first resp_valid.
   task automatic do_txn(input logic w, input logic [15:0] a, input logic [15:0] d,
                         output logic [15:0] rd, output logic rw, output logic re,
                         output int lat, output bit ok);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      ok = 1'b0; lat = 0; rd = '0; rw = 1'b0; re = 1'b0;
      for (int n = 0; n < 40 && !req_ready; n++) @(negedge clk);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!resp_valid) return;
      rd = resp_rdata; rw = resp_write; re = resp_err;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      ok = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else passed++;
      total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else passed++;
      total++; if (resp_rdata !== 16'h0) $display("FAIL reset_resp_rdata: got %h want 0000", resp_rdata); else passed++;
      total++; if (resp_write !== 1'b0) $display("FAIL reset_resp_write: got %b want 0", resp_write); else passed++;
      total++; if (resp_err !== 1'b0) $display("FAIL reset_resp_err: got %b want 0", resp_err); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
      total++; if (z_req_ready !== 1'b1) $display("FAIL reset_lat0_req_ready: got %b want 1", z_req_ready); else passed++;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_store_load();
      logic [15:0] rd, exp_rd;
      logic rw, re, exp_e;
      int lat;
      bit ok;
      model_txn(1'b1, 16'h0010, 16'hBEEF, exp_rd, exp_e);
      do_txn(1'b1, 16'h0010, 16'hBEEF, rd, rw, re, lat, ok);
      total++; if (ok !== 1'b1) $display("FAIL store_done: got %b want 1", ok); else passed++;
      total++; if (re !== exp_e) $display("FAIL store_err: got %b want %b", re, exp_e); else passed++;
      total++; if (rd !== exp_rd) $display("FAIL store_rdata: got %h want %h", rd, exp_rd); else passed++;
      total++; if (rw !== 1'b1) $display("FAIL store_write_echo: got %b want 1", rw); else passed++;
      total++; if (lat !== LAT + 2) $display("FAIL store_latency: got %0d want %0d", lat, LAT + 2); else passed++;
      model_txn(1'b0, 16'h0010, 16'h0000, exp_rd, exp_e);
      do_txn(1'b0, 16'h0010, 16'h0000, rd, rw, re, lat, ok);
      total++; if (ok !== 1'b1) $display("FAIL load_done: got %b want 1", ok); else passed++;
      total++; if (rd !== exp_rd) $display("FAIL load_rdata: got %h want %h", rd, exp_rd); else passed++;
      total++; if (rw !== 1'b0) $display("FAIL load_write_echo: got %b want 0", rw); else passed++;
      total++; if (lat !== LAT + 2) $display("FAIL load_latency: got %0d want %0d", lat, LAT + 2); else passed++;
   endtask

   task automatic test_errors();
      logic        ws [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [15:0] as [8] = '{16'h0011, 16'h0200, 16'h0000, 16'hFFFE,
                              16'h8010, 16'h0010, 16'h0013, 16'h0012};
      logic [15:0] ds [8] = '{16'h0, 16'h1234, 16'h0, 16'h0, 16'h9999, 16'h0, 16'h0101, 16'h0};
      logic [15:0] rd, exp_rd;
      logic rw, re, exp_e;
      int lat;
      bit ok;
      for (int i = 0; i < 8; i++) begin
         model_txn(ws[i], as[i], ds[i], exp_rd, exp_e);
         do_txn(ws[i], as[i], ds[i], rd, rw, re, lat, ok);
         total++; if (ok !== 1'b1) $display("FAIL err_done[%0d]: got %b want 1", i, ok); else passed++;
         total++; if (re !== exp_e) $display("FAIL err_flag[%0d] addr %h: got %b want %b", i, as[i], re, exp_e); else passed++;
         total++; if (rd !== exp_rd) $display("FAIL err_rdata[%0d] addr %h: got %h want %h", i, as[i], rd, exp_rd); else passed++;
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] rd, exp_rd;
      logic rw, re, exp_e;
      int lat;
      bit ok;
      bit seen;
      model_txn(1'b1, 16'h01FE, 16'h5A5A, exp_rd, exp_e);
      do_txn(1'b1, 16'h01FE, 16'h5A5A, rd, rw, re, lat, ok);
      total++; if (re !== exp_e) $display("FAIL bp_preload_err: got %b want %b", re, exp_e); else passed++;
      model_txn(1'b0, 16'h01FE, 16'h0000, exp_rd, exp_e);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h01FE; req_wdata = '0;
      for (int n = 0; n < 40 && !req_ready; n++) @(negedge clk);
      @(negedge clk);
      // Second request held valid all through the first one's life.
      req_write = 1'b1; req_addr = 16'h0030; req_wdata = 16'h7777;
      lat = 1;
      while (!resp_valid && lat < 40) begin
         total++; if (req_ready !== 1'b0) $display("FAIL bp_ready_busy: got %b want 0", req_ready); else passed++;
         @(negedge clk);
         lat++;
      end
      total++; if (lat !== LAT + 2) $display("FAIL bp_latency: got %0d want %0d", lat, LAT + 2); else passed++;
      for (int i = 0; i < 5; i++) begin
         total++; if (resp_valid !== 1'b1) $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, resp_valid); else passed++;
         total++; if (resp_rdata !== exp_rd) $display("FAIL bp_hold_rdata[%0d]: got %h want %h", i, resp_rdata, exp_rd); else passed++;
         total++; if (req_ready !== 1'b0) $display("FAIL bp_hold_ready[%0d]: got %b want 0", i, req_ready); else passed++;
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      total++; if (resp_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", resp_valid); else passed++;
      total++; if (req_ready !== 1'b1) $display("FAIL bp_ready_rise: got %b want 1", req_ready); else passed++;
      model_txn(1'b1, 16'h0030, 16'h7777, exp_rd, exp_e);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      total++; if (lat !== LAT + 2) $display("FAIL bp_second_latency: got %0d want %0d", lat, LAT + 2); else passed++;
      total++; if (resp_write !== 1'b1) $display("FAIL bp_second_write: got %b want 1", resp_write); else passed++;
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      seen = 1'b0;
      repeat (LAT + 4) begin
         if (resp_valid) seen = 1'b1;
         @(negedge clk);
      end
      total++; if (seen !== 1'b0) $display("FAIL bp_no_extra_resp: got %b want 0", seen); else passed++;
      model_txn(1'b0, 16'h0030, 16'h0000, exp_rd, exp_e);
      do_txn(1'b0, 16'h0030, 16'h0000, rd, rw, re, lat, ok);
      total++; if (rd !== exp_rd) $display("FAIL bp_second_stored: got %h want %h", rd, exp_rd); else passed++;
   endtask

   task automatic test_reset_mid();
      logic [15:0] rd, exp_rd;
      logic rw, re, exp_e;
      int lat;
      bit ok;
      // Reset during WAIT: store dropped.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'hCAFE;
      for (int n = 0; n < 40 && !req_ready; n++) @(negedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      total++; if (busy !== 1'b1) $display("FAIL rw_busy_before: got %b want 1", busy); else passed++;
      rst = 1'b1;
      #1;
      total++; if (req_ready !== 1'b1) $display("FAIL rw_req_ready: got %b want 1", req_ready); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rw_busy: got %b want 0", busy); else passed++;
      total++; if (resp_valid !== 1'b0) $display("FAIL rw_resp_valid: got %b want 0", resp_valid); else passed++;
      @(negedge clk);
      rst = 1'b0;
      model_txn(1'b0, 16'h0020, 16'h0000, exp_rd, exp_e);
      do_txn(1'b0, 16'h0020, 16'h0000, rd, rw, re, lat, ok);
      total++; if (rd !== exp_rd) $display("FAIL rw_store_dropped: got %h want %h", rd, exp_rd); else passed++;
      // Reset during RESP: store already committed.
      req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0040; req_wdata = 16'h4242;
      for (int n = 0; n < 40 && !req_ready; n++) @(negedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      for (int n = 0; n < 40 && !resp_valid; n++) @(negedge clk);
      total++; if (resp_valid !== 1'b1) $display("FAIL rr_reached_resp: got %b want 1", resp_valid); else passed++;
      rst = 1'b1;
      #1;
      total++; if (resp_valid !== 1'b0) $display("FAIL rr_resp_valid: got %b want 0", resp_valid); else passed++;
      @(negedge clk);
      rst = 1'b0;
      model_txn(1'b1, 16'h0040, 16'h4242, exp_rd, exp_e);
      model_txn(1'b0, 16'h0040, 16'h0000, exp_rd, exp_e);
      do_txn(1'b0, 16'h0040, 16'h0000, rd, rw, re, lat, ok);
      total++; if (rd !== exp_rd) $display("FAIL rr_store_kept: got %h want %h", rd, exp_rd); else passed++;
   endtask

   task automatic test_random();
      logic [15:0] a, d, rd, exp_rd;
      logic w, rw, re, exp_e;
      int lat, r, idx;
      bit ok;
      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7) begin
            idx = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) idx += 240;
            a = 16'(idx * 2);
         end else if (r == 7) begin
            a = 16'(int'($urandom_range(0, 511)) * 2 + 1);
         end else begin
            a = 16'(int'($urandom_range(256, 32767)) * 2);
         end
         w = 1'($urandom_range(0, 1));
         d = 16'($urandom);
         model_txn(w, a, d, exp_rd, exp_e);
         do_txn(w, a, d, rd, rw, re, lat, ok);
         total++; if (ok !== 1'b1) $display("FAIL rnd_done[%0d]: got %b want 1", i, ok); else passed++;
         total++; if (rd !== exp_rd) $display("FAIL rnd_rdata[%0d] w=%b a=%h: got %h want %h", i, w, a, rd, exp_rd); else passed++;
         total++; if (re !== exp_e) $display("FAIL rnd_err[%0d] a=%h: got %b want %b", i, a, re, exp_e); else passed++;
         total++; if (rw !== w) $display("FAIL rnd_write[%0d]: got %b want %b", i, rw, w); else passed++;
         total++; if (lat !== LAT + 2) $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, LAT + 2); else passed++;
      end
   endtask

   task automatic test_latency0();
      logic        ws [3] = '{1'b0, 1'b1, 1'b0};
      logic [15:0] as [3] = '{16'h0000, 16'h0002, 16'h0002};
      logic [15:0] ds [3] = '{16'h0000, 16'hABCD, 16'h0000};
      logic [15:0] es [3] = '{16'h0000, 16'h0000, 16'hABCD};
      int lat;
      for (int i = 0; i < 3; i++) begin
         z_req_valid = 1'b1; z_req_write = ws[i]; z_req_addr = as[i]; z_req_wdata = ds[i];
         for (int n = 0; n < 40 && !z_req_ready; n++) @(negedge clk);
         @(negedge clk);
         z_req_valid = 1'b0;
         lat = 1;
         while (!z_resp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
         end
         total++; if (lat !== 2) $display("FAIL lat0_latency[%0d]: got %0d want 2", i, lat); else passed++;
         total++; if (z_resp_rdata !== es[i]) $display("FAIL lat0_rdata[%0d]: got %h want %h", i, z_resp_rdata, es[i]); else passed++;
         total++; if (z_resp_err !== 1'b0) $display("FAIL lat0_err[%0d]: got %b want 0", i, z_resp_err); else passed++;
         z_resp_ready = 1'b1;
         @(negedge clk);
         z_resp_ready = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
      @(negedge clk);
      test_reset();
      test_latency0();
      test_store_load();
      test_errors();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout want completion");
      $fatal(1, "timeout");
   end

endmodule
